reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port integer register file; next generation of the single-issue 2R/1W file.
//  Configurable width, depth, read ports and write ports, with priority resolution between write ports.
//  Optional same-cycle write-to-read bypass, optional hardwired-zero x0.
//  Hardware clear sequencer: after reset or on request, zeroes every entry (one per cycle) with a busy flag.
//  Sits between decode (read ports) and writeback (write ports) of the multi-issue core.
// PARAMETERS
//  XLEN     32  data width of each register
//  NREGS    32  number of registers; need not be a power of two
//  NRD       2  number of read ports
//  NWR       2  number of write ports; higher index = higher priority
//  BYPASS    1  1: a read sees same-cycle write data; 0: a read sees the stored value
//  ZERO_REG  1  1: entry 0 always reads 0 and ignores writes
//  AW        $clog2(NREGS)  address width (derived, not overridable)
// PORTS
//  clk      in   1         clock; all state updates on posedge
//  rst_n    in   1         synchronous, active-low reset
//  clr_req  in   1         pulse: start a full clear sequence (sampled only in IDLE)
//  clr_busy out  1         1 while the clear sequence runs
//  we       in   NWR       per-port write enable
//  waddr    in   NWR*AW    write addresses; port k uses [k*AW +: AW]
//  wdata    in   NWR*XLEN  write data; port k uses [k*XLEN +: XLEN]
//  raddr    in   NRD*AW    read addresses; port j uses [j*AW +: AW]
//  rdata    out  NRD*XLEN  read data (combinational); port j uses [j*XLEN +: XLEN]
// BEHAVIOUR
//  FSM states: CLEAR, IDLE. clr_busy = (state == CLEAR).
//  Reset: rst_n low at a posedge -> state=CLEAR, clr_idx=0; register contents are not touched that edge.
//  CLEAR: at each posedge with rst_n high, mem[clr_idx] <= 0 and clr_idx++.
//   When clr_idx == NREGS-1, the transition to IDLE happens on that same edge.
//   clr_busy is therefore high for exactly NREGS cycles after reset release.
//  IDLE: clr_req=1 at a posedge -> CLEAR with clr_idx=0; clr_busy rises the next cycle.
//   While clr_busy=1, clr_req is ignored.
//  Reset mid-clear restarts the sequence at clr_idx=0.
//  While clr_busy=1: all we ignored (writes dropped, not queued); every rdata port = 0.
//  Write (IDLE only): at the posedge, for each address the highest-index port k with we[k]=1 wins.
//   Winning port writes mem[waddr_k] <= wdata_k.
//   Ports to different addresses all commit in the same cycle.
//  Ignored writes: waddr >= NREGS; waddr == 0 when ZERO_REG=1.
//  Read: combinational, zero cycles of latency. rdata_j = 0 if raddr_j >= NREGS or (ZERO_REG and raddr_j == 0).
//   BYPASS=1: if any enabled write targets raddr_j this cycle (and IDLE), rdata_j = winning wdata.
//   Otherwise rdata_j = mem[raddr_j].
//   Any number of read ports may share an address.
//  mem contents are undefined from power-up until the first clear completes. rdata is 0 during clear.
// TESTING
//  1. Release rst_n -> clr_busy=1 for exactly NREGS(32) cycles, then 0; every address reads 0; write in cycle 5 dropped.
//  2. IDLE: we=2'b11, waddr0=waddr1=7, wdata0=0xAAAA, wdata1=0x5555 -> mem[7]=0x5555.
//     Same cycle, with BYPASS=1, raddr0=7 gives 0x5555.
//  3. we0=1 waddr0=0 wdata0=0xFFFF_FFFF (ZERO_REG=1) -> raddr=0 reads 0 same cycle and next cycle.
//  4. Write 0x1234 to x3 and 0xBEEF to x4 in one cycle -> next cycle raddr0=3, raddr1=4 read 0x1234, 0xBEEF.
//  5. clr_req pulse, then rst_n low for 1 cycle at clr_idx=10 -> busy restarts; 32 more busy cycles; all regs 0.
//  6. NREGS=24, BYPASS=0: write waddr=30 is ignored and raddr=30 reads 0.
//     Write x5=0x77 -> same-cycle raddr=5 shows old value, next cycle 0x77.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bus between decode/writeback and the multi-port register file
interface reg_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = NREGS > 1 ? $clog2(NREGS) : 1;
  logic                clr_req;
  logic                clr_busy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  modport master (output clr_req, we, waddr, wdata, raddr, input clr_busy, rdata);
  modport slave  (input clr_req, we, waddr, wdata, raddr, output clr_busy, rdata);
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write priority, optional bypass and x0, and clear sequencer
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);
  localparam int AW = NREGS > 1 ? $clog2(NREGS) : 1;
  typedef enum logic {CLEAR, IDLE} state_e;
  state_e            state_q, state_d;
  logic [AW-1:0]     clr_idx_q, clr_idx_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];
  logic [NREGS-1:0]  wen;
  logic [XLEN-1:0]   wdat [NREGS];
  logic [AW-1:0]     ra;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) mem_q <= mem_d;
  end
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      state_d   = (clr_idx_q == AW'(NREGS - 1)) ? IDLE : CLEAR;
    end else if (bus.clr_req) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
    end
  end
  // per-entry winner: later (higher-index) ports overwrite earlier ones
  always_comb begin
    wen = '0;
    for (int i = 0; i < NREGS; i++) begin
      wdat[i] = '0;
      if (!(ZERO_REG && i == 0) && state_q == IDLE)
        for (int k = 0; k < NWR; k++)
          if (bus.we[k] && bus.waddr[k*AW +: AW] == AW'(i)) begin
            wen[i]  = 1'b1;
            wdat[i] = bus.wdata[k*XLEN +: XLEN];
          end
    end
  end
  always_comb begin
    mem_d = mem_q;
    if (state_q == CLEAR) mem_d[clr_idx_q] = '0;
    else
      for (int i = 0; i < NREGS; i++)
        if (wen[i]) mem_d[i] = wdat[i];
  end
  assign bus.clr_busy = (state_q == CLEAR);
  always_comb begin
    bus.rdata = '0;
    ra = '0;
    for (int j = 0; j < NRD; j++) begin
      ra = bus.raddr[j*AW +: AW];
      if (state_q == IDLE && {1'b0, ra} < (AW+1)'(NREGS) && !(ZERO_REG && ra == '0))
        bus.rdata[j*XLEN +: XLEN] = (BYPASS && wen[ra]) ? wdat[ra] : mem_q[ra];
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for a default instance and a 24-entry, no-bypass instance
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  typedef struct {int d; int p; logic [31:0] e; string t;} exp_t;
  exp_t sb[$];
  reg_file_mp_if b0 ();
  reg_file_mp_if #(.NREGS(24)) b1 ();
  reg_file_mp u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  reg_file_mp #(.NREGS(24), .BYPASS(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  function automatic logic [31:0] obs(int d, int p);
    if (p < 0) return d == 0 ? {31'b0, b0.clr_busy} : {31'b0, b1.clr_busy};
    return d == 0 ? b0.rdata[p*32 +: 32] : b1.rdata[p*32 +: 32];
  endfunction
  task automatic check(string t, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask
  task automatic push(int d, int p, logic [31:0] e, string t);
    exp_t x;
    x.d = d; x.p = p; x.e = e; x.t = t;
    sb.push_back(x);
  endtask
  task automatic cyc();
    exp_t x;
    #2;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check(x.t, obs(x.d, x.p), x.e);
    end
    @(negedge clk);
    b0.we = '0; b1.we = '0; b0.clr_req = 1'b0;
  endtask
  task automatic rd(int d, int p, logic [4:0] a, logic [31:0] e, string t);
    if (d == 0) b0.raddr[p*5 +: 5] = a; else b1.raddr[p*5 +: 5] = a;
    push(d, p, e, t);
  endtask
  task automatic wr(int d, int k, logic [4:0] a, logic [31:0] v);
    if (d == 0) begin
      b0.we[k] = 1'b1; b0.waddr[k*5 +: 5] = a; b0.wdata[k*32 +: 32] = v;
    end else begin
      b1.we[k] = 1'b1; b1.waddr[k*5 +: 5] = a; b1.wdata[k*32 +: 32] = v;
    end
  endtask
  task automatic busy_run(string t);
    for (int i = 0; i < 36; i++) begin
      push(0, -1, {31'b0, i < 32}, $sformatf("%s_busy0_%0d", t, i));
      push(1, -1, {31'b0, i < 24}, $sformatf("%s_busy1_%0d", t, i));
      if (i == 5) begin
        wr(0, 0, 5'd9, 32'hDEAD_BEEF);
        rd(0, 0, 5'd9, 32'h0, {t, "_rd_during_clr"});
      end
      cyc();
    end
  endtask
  task automatic all_zero(string t);
    for (int a = 0; a < 32; a++) begin
      rd(0, 0, 5'(a), 32'h0, $sformatf("%s_z0_%0d", t, a));
      rd(1, 1, 5'(a), 32'h0, $sformatf("%s_z1_%0d", t, a));
      cyc();
    end
  endtask
  initial begin
    rst_n = 1'b0;
    b0.clr_req = 1'b0; b0.we = '0; b0.waddr = '0; b0.wdata = '0; b0.raddr = '0;
    b1.clr_req = 1'b0; b1.we = '0; b1.waddr = '0; b1.wdata = '0; b1.raddr = '0;
    cyc();
    push(0, -1, 32'd1, "rst_busy");
    cyc();
    rst_n = 1'b1;
    busy_run("init");
    all_zero("init");
    wr(0, 0, 5'd7, 32'hAAAA); wr(0, 1, 5'd7, 32'h5555);
    rd(0, 0, 5'd7, 32'h5555, "prio_bypass");
    cyc();
    rd(0, 0, 5'd7, 32'h5555, "prio_stored");
    cyc();
    wr(0, 0, 5'd0, 32'hFFFF_FFFF);
    rd(0, 0, 5'd0, 32'h0, "x0_same");
    cyc();
    rd(0, 0, 5'd0, 32'h0, "x0_next");
    cyc();
    wr(0, 0, 5'd3, 32'h1234); wr(0, 1, 5'd4, 32'hBEEF);
    rd(0, 0, 5'd3, 32'h1234, "dual_byp3");
    rd(0, 1, 5'd4, 32'hBEEF, "dual_byp4");
    cyc();
    rd(0, 0, 5'd3, 32'h1234, "dual_rd3");
    rd(0, 1, 5'd4, 32'hBEEF, "dual_rd4");
    cyc();
    rd(0, 0, 5'd4, 32'hBEEF, "share_a");
    rd(0, 1, 5'd4, 32'hBEEF, "share_b");
    cyc();
    wr(0, 0, 5'd9, 32'h99);
    cyc();
    rd(0, 0, 5'd9, 32'h99, "pre_clr");
    b0.clr_req = 1'b1;
    push(0, -1, 32'd0, "clr_req_idle");
    cyc();
    for (int i = 0; i < 10; i++) begin
      push(0, -1, 32'd1, $sformatf("req_busy_%0d", i));
      rd(0, 0, 5'd9, 32'h0, $sformatf("req_rd_%0d", i));
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    busy_run("restart");
    all_zero("restart");
    wr(1, 0, 5'd30, 32'h55);
    rd(1, 0, 5'd30, 32'h0, "oob_same");
    cyc();
    rd(1, 0, 5'd30, 32'h0, "oob_next");
    cyc();
    wr(1, 0, 5'd5, 32'h77);
    rd(1, 1, 5'd5, 32'h0, "nobyp_old");
    cyc();
    rd(1, 1, 5'd5, 32'h77, "nobyp_new");
    cyc();
    wr(1, 0, 5'd23, 32'h11); wr(1, 1, 5'd23, 32'h22);
    cyc();
    rd(1, 0, 5'd23, 32'h22, "prio_top");
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
